// File: rtl/gate_test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_test_pkg
// Description : Shared types and truth-table constants for the two-input gate
//               exerciser (FSM states, vector index, reference tables).
// Revision    : 1.0 - initial release
// ============================================================================
package gate_test_pkg;

   // Exerciser FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Input vector index; bit 1 drives b, bit 0 drives a
   typedef logic [1:0] vec_idx_t;

   // Reference truth tables, bit index = {b,a}
   localparam logic [3:0] TT_AND = 4'b1000;
   localparam logic [3:0] TT_OR  = 4'b1110;
   localparam logic [3:0] TT_NOR = 4'b0001;
   localparam logic [3:0] TT_XOR = 4'b0110;

endpackage : gate_test_pkg
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : settle_timer
// Description : Loadable down-counter with enable and zero flag; times how
//               long each stimulus vector is held before sampling.
// Revision    : 1.0 - initial release
// ============================================================================
module settle_timer #(
   parameter int WIDTH = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_zero
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Load has priority; count saturates at zero when enabled
   always_comb begin
      count_d = count_q;
      if (i_load) begin
         count_d = i_load_val;
      end else if (i_en && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   // Counter register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_zero = (count_q == '0);

endmodule : settle_timer
`default_nettype wire

// File: rtl/gate_exerciser.sv
`default_nettype none
// ============================================================================
// Module      : gate_exerciser
// Description : Drives all four input vectors onto a two-input gate, samples
//               its output after a settle time and compares the observed
//               truth table against an expected one.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_exerciser
   import gate_test_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic [3:0] i_expected,
   output logic       o_a,
   output logic       o_b,
   input  logic       i_c,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_pass,
   output logic [3:0] o_observed,
   output logic [3:0] o_fail_mask
);

   localparam int               CNT_W  = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

   generate
      if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 255)) begin : g_param_check
         $error("gate_exerciser: SETTLE_CYCLES must be within 1..255");
      end
   endgenerate

   state_t     state_q, state_d;
   vec_idx_t   idx_q, idx_d;
   logic [3:0] exp_q, exp_d;
   logic [3:0] obs_q, obs_d;
   logic [3:0] mask_q, mask_d;
   logic       pass_q, pass_d;
   logic       done_q, done_d;
   logic       busy_q, busy_d;
   logic       tmr_load;
   logic       tmr_en;
   logic       tmr_zero;

   settle_timer #(
      .WIDTH (CNT_W)
   ) u_settle_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (tmr_load),
      .i_load_val (RELOAD),
      .i_en       (tmr_en),
      .o_zero     (tmr_zero)
   );

   // Next-state, stimulus and result computation
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      exp_d    = exp_q;
      obs_d    = obs_q;
      mask_d   = mask_q;
      pass_d   = pass_q;
      done_d   = 1'b0;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               exp_d    = i_expected;
               idx_d    = 2'd0;
               tmr_load = 1'b1;
               obs_d    = 4'b0000;
               mask_d   = 4'b0000;
               pass_d   = 1'b0;
               state_d  = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            tmr_en = 1'b1;
            if (tmr_zero) begin
               state_d = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            obs_d[idx_q] = i_c;
            if (idx_q != 2'd3) begin
               idx_d    = idx_q + 2'd1;
               tmr_load = 1'b1;
               state_d  = ST_SETTLE;
            end else begin
               // Results are registered together with the last sample so
               // they are valid in the same cycle as the done pulse.
               mask_d  = obs_d ^ exp_q;
               pass_d  = (obs_d == exp_q);
               done_d  = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            idx_d   = 2'd0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and result registers; reset aborts any run in progress
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         idx_q   <= 2'd0;
         exp_q   <= 4'b0000;
         obs_q   <= 4'b0000;
         mask_q  <= 4'b0000;
         pass_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         exp_q   <= exp_d;
         obs_q   <= obs_d;
         mask_q  <= mask_d;
         pass_q  <= pass_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   // Stimulus is the registered vector index itself
   assign o_a         = idx_q[0];
   assign o_b         = idx_q[1];
   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_pass      = pass_q;
   assign o_observed  = obs_q;
   assign o_fail_mask = mask_q;

endmodule : gate_exerciser
`default_nettype wire

// File: doc/gate_exerciser.md
Name: gate_exerciser

Overview:
- Sequential stimulus/response engine for the two-input combinational gates: the driving and checking end of the a/b -> c gate interface.
- On a start request, drives all four input vectors onto a gate under test, waits a settle time per vector, samples the gate output and compares the 4-entry observed truth table against an expected one.
- Sits beside any two-input gate in the design or bench as a built-in self-test.

Parameters:
- SETTLE_CYCLES, 2, clock cycles each vector is held before sampling; legal range 1..255, elaboration error otherwise.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_start  input  1  start request; accepted only in IDLE.
- i_expected  input  4  expected truth table; bit index = {b,a}; captured on start acceptance.
- o_a  output  1  drive to gate input a.
- o_b  output  1  drive to gate input b.
- i_c  input  1  gate output, combinational from o_a/o_b; no synchroniser.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle pulse when results become valid.
- o_pass  output  1  1 when observed equals expected; valid from o_done until next start acceptance.
- o_observed  output  4  sampled truth table, same bit indexing.
- o_fail_mask  output  4  observed XOR expected.

Behaviour:
- Reset (async, i_rst=1): state IDLE; o_a, o_b, o_busy, o_done, o_pass = 0; o_observed, o_fail_mask = 4'b0000; vector index = 0; captured expected = 0. Reset mid-run aborts immediately; there is no partial result and no o_done.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE with i_start=1 at an edge (acceptance):
  - capture i_expected; idx=0; {o_b,o_a}=2'b00; settle count = SETTLE_CYCLES-1.
  - clear o_pass, o_observed, o_fail_mask.
  - go SETTLE.
- SETTLE: hold {o_b,o_a}=idx. Decrement the count each cycle; at count 0 go SAMPLE. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle): at the closing edge, o_observed[idx] <= i_c.
  - If idx<3: idx+1, drive the new vector, reload the count, go SETTLE.
  - If idx==3: go DONE. Stimulus keeps its last value {1,1}.
- DONE (1 cycle): o_done=1; o_pass and o_fail_mask computed from the full observed table and registered (no combinational path from i_c). Next state IDLE; o_a/o_b return to 0.
- Latency: the first cycle after acceptance is cycle 1. o_done is high in cycle 4*(SETTLE_CYCLES+1)+1, which is 13 for the default.
- o_busy is high from cycle 1 through the DONE cycle inclusive.
- i_start while busy (including DONE) is ignored, with no queuing. i_start held high continuously restarts one cycle after DONE.
- i_expected changes after acceptance have no effect.
- Results hold stable in IDLE until the next acceptance.
- All outputs are registered.

Decomposition:
- Shared package gate_test_pkg:
  - state enum type.
  - truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_NOR=4'b0001, TT_XOR=4'b0110.
  - vector-index typedef (2 bits).
- One natural sub-module, settle_timer: loadable down-counter of width $clog2(SETTLE_CYCLES+1) with load, enable and zero flag.
- FSM, vector index and result registers stay in gate_exerciser.

Test Plan:
- AND gate connected, i_expected=TT_AND, SETTLE_CYCLES=2, pulse i_start -> o_done in cycle 13, o_observed=1000, o_fail_mask=0000, o_pass=1; o_busy high cycles 1-13.
- OR gate connected, i_expected=TT_OR -> o_observed=1110, o_pass=1.
- NOR gate connected, i_expected=TT_AND -> o_observed=0001, o_fail_mask=1001, o_pass=0.
- i_c tied 0, i_expected=TT_OR -> o_observed=0000, o_fail_mask=1110, o_pass=0. Also check o_a/o_b sequence 00,01,10,11 with each held 2 cycles before sample.
- Assert i_rst in cycle 6 of a run -> all outputs 0 immediately (async), no o_done. A new start after reset completes normally with correct results.
- i_start re-pulsed in cycles 3 and 13 -> ignored (single o_done at cycle 13, results unchanged). A start in IDLE afterwards is accepted and results clear at acceptance.
